// File: rtl/vga_frame_fetch_if.sv
// Frame memory read port: the fetch engine drives the address and strobe,
// the memory returns one coded colour byte a fixed latency later.
interface vga_frame_fetch_if #(
   parameter int ADDR_W = 16
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_rdata;

   modport master (output mem_addr, output mem_rd_en, input mem_rdata);
   modport slave  (input mem_addr, input mem_rd_en, output mem_rdata);
endinterface

// File: rtl/vga_frame_fetch.sv
// VGA timing generator plus frame-memory fetch. Scans h/v counters, reads one
// coded colour per in-window pixel, and delays sync/blank/frame markers so
// every output leaves the block MEM_LAT+2 clocks after its counter cycle.
module vga_frame_fetch #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int X0       = 192,
   parameter int Y0       = 112,
   parameter int MEM_LAT  = 2,
   parameter int ADDR_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   vga_frame_fetch_if.master     mem,
   output logic [7:0]            codedColor,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  blank_n,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // Illegal configurations stop elaboration instead of producing bad video.
   if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("vga_frame_fetch: MEM_LAT must be 1..4");
   end
   if (X0 + IMG_W > H_ACTIVE || Y0 + IMG_H > V_ACTIVE ||
       longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_win
      $error("vga_frame_fetch: image window does not fit");
   end

   // Per-pixel control bits that travel alongside the memory read.
   typedef struct packed {
      logic in_win;
      logic vis;
      logic hs_n;
      logic vs_n;
      logic first;
   } pix_ctl_t;

   // Idle pattern: syncs deasserted, nothing visible, no frame marker.
   localparam pix_ctl_t CTL_IDLE = '{in_win: 1'b0, vis: 1'b0, hs_n: 1'b1,
                                     vs_n: 1'b1, first: 1'b0};

   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic              h_last;
   logic              v_last;
   logic              h_in_win;
   logic              v_in_win;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] col_off;
   pix_ctl_t          cur;
   pix_ctl_t          pipe [1:MEM_LAT+1];
   pix_ctl_t          tail;

   // Stage 0 decode of the current counter position.
   assign h_last   = (h == HW'(H_TOTAL - 1));
   assign v_last   = (v == VW'(V_TOTAL - 1));
   assign h_in_win = (h >= HW'(X0)) && (h < HW'(X0 + IMG_W));
   assign v_in_win = (v >= VW'(Y0)) && (v < VW'(Y0 + IMG_H));
   assign col_off  = ADDR_W'(h) - ADDR_W'(X0);

   assign cur = '{
      in_win: h_in_win && v_in_win,
      vis:    (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE)),
      hs_n:   !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC))),
      vs_n:   !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC))),
      first:  (h == '0) && (v == '0)
   };

   // Horizontal and vertical scan counters; both wrap together at frame end.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (h_last) begin
         h <= '0;
         v <= v_last ? '0 : v + VW'(1);
      end else begin
         h <= h + HW'(1);
      end
   end

   // Row base address: advances one image row after each in-window line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_base <= '0;
      end else if (h_last) begin
         if (v_last) begin
            row_base <= '0;
         end else if (v_in_win) begin
            row_base <= row_base + ADDR_W'(IMG_W);
         end
      end
   end

   // Stage 1 read request; the address holds outside the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem.mem_addr  <= '0;
         mem.mem_rd_en <= 1'b0;
      end else begin
         mem.mem_rd_en <= cur.in_win;
         if (cur.in_win) begin
            mem.mem_addr <= row_base + col_off;
         end
      end
   end

   // Control shift pipeline matching the memory read latency.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every stage is reset (to the idle pattern, syncs high) so no
      // stale sync or colour from before reset can reach the outputs.
      if (rst) begin
         for (int i = 1; i <= MEM_LAT + 1; i++) begin
            pipe[i] <= CTL_IDLE;
         end
      end else begin
         pipe[1] <= cur;
         for (int i = 2; i <= MEM_LAT + 1; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tail = pipe[MEM_LAT+1];

   // Output register: colour merged with background, delayed sync/blank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         codedColor  <= 8'h00;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank_n     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         codedColor  <= (tail.in_win && tail.vis) ? mem.mem_rdata : 8'h00;
         hsync       <= tail.hs_n;
         vsync       <= tail.vs_n;
         blank_n     <= tail.vis;
         frame_start <= tail.first;
      end
   end

endmodule

// File: doc/vga_frame_fetch.md
Name: vga_frame_fetch

Overview:
Generates 640x480@60 VGA timing and fetches one 8-bit coded colour per active pixel from the sprite/frame memory. It produces the `codedColor` byte consumed by the colour decoder stage, with sync and blank pipelined to match the memory read latency. An image window of IMG_W x IMG_H pixels is placed at (X0,Y0). Pixels outside the window output background code 8'h00.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 256, image width in pixels
IMG_H, 256, image height in lines
X0, 192, image left column
Y0, 112, image top line
MEM_LAT, 2, memory read latency in clocks (1..4)
ADDR_W, 16, memory address width

Ports:
clk  in  1  pixel clock (25 MHz)
rst  in  1  asynchronous, active-high reset
mem_addr  out  ADDR_W  frame memory read address
mem_rd_en  out  1  read strobe, high only for in-window pixels
mem_rdata  in  8  read data, valid MEM_LAT clocks after the address cycle
codedColor  out  8  coded colour for the colour decoder
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
blank_n  out  1  high during the visible area
frame_start  out  1  one-clock pulse aligned with output pixel (0,0)

Behaviour:
- Reset values: all outputs are 0 except hsync=1 and vsync=1. Counters and all pipeline stages clear. Reset is honoured asynchronously at any time, including mid-line or mid-frame. The first output pixel after release is (0,0).
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800).
  - v increments when h wraps. v runs 0..V_TOTAL-1 (525) and then wraps to 0.
- Stage 0 (cycle t): the counters hold (h,v). Compute:
  - in_win = (X0 ≤ h < X0+IMG_W) and (Y0 ≤ v < Y0+IMG_H)
  - vis = h < H_ACTIVE and v < V_ACTIVE
  - hs_n = not (H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC)
  - vs_n = the same test applied to v
- Address generation:
  - Computed incrementally, with no multiplier. A row_base register is 0 at v=Y0. It increments by IMG_W at the end of each in-window line and resets at frame wrap.
  - mem_addr = row_base + (h−X0), truncated to ADDR_W.
- Stage 1 (t+1): mem_addr and mem_rd_en=in_win are registered. When not in_win, mem_addr holds its last value.
- Stages 1..MEM_LAT+1: a shift pipeline carries in_win, vis, hs_n, vs_n and first (h==0 && v==0).
- Output (t+MEM_LAT+2): all outputs are registered.
  - codedColor = in_win_d ? mem_rdata : 8'h00, and forced to 8'h00 when vis_d=0.
  - hsync, vsync, blank_n and frame_start come from the delayed bits.
- Latency L = MEM_LAT+2 clocks, identical for every output, so sync/colour alignment is exact.
- Boundary cases:
  - Window fully inside the active area (parameter legality): X0+IMG_W ≤ H_ACTIVE, Y0+IMG_H ≤ V_ACTIVE, IMG_W·IMG_H ≤ 2^ADDR_W.
  - The last in-window pixel reads address IMG_W·IMG_H−1. The next frame restarts at 0.
  - Frame wrap and line wrap occur in the same cycle at (H_TOTAL−1, V_TOTAL−1). Both counters return to 0 and row_base clears.
  - mem_rdata is ignored whenever the delayed in_win bit is 0.

Test Plan:
- Reset: assert rst mid-frame -> outputs immediately hsync=1, vsync=1, blank_n=0, codedColor=0, mem_rd_en=0. After release, frame_start pulses exactly at cycle L.
- Line timing: with MEM_LAT=2, count from frame_start -> blank_n high for 640 clocks, hsync low at output clocks 656..751 of each line, line period 800.
- Frame timing -> vsync low for lines 490..491, frame_start period exactly 420000 clocks, one pulse per frame.
- Address sequence -> mem_addr=0 at (192,112), 255 at (447,112), 256 at (192,113), 65535 at (447,367). mem_rd_en low at (191,112) and (448,112).
- Data alignment: memory model returns addr[7:0] with MEM_LAT=1, then MEM_LAT=3 -> codedColor at output pixel (192+k,112) equals k for k=0..255. codedColor is 0 at pixel (191,112) and in blanking.
- Reset mid-line: assert rst at h=300, v=200, release 5 clocks later -> counters restart at (0,0) and the pipeline emits no stale data (codedColor=0 until valid window pixels).
